// File: rtl/demux32_des.sv
// 1:32 serial-to-parallel deserializer with bitslip alignment.
// The slot counter is exported on S0..S4 so a transmit-side 32:1 mux can run in lockstep.
module demux32_des #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CE,
    input  logic        D,
    input  logic        CALIB,
    output logic [31:0] Q,
    output logic        VALID,
    output logic        S0,
    output logic        S1,
    output logic        S2,
    output logic        S3,
    output logic        S4
);

    logic [4:0]  cnt_q, cnt_d;
    logic [30:0] stg_q, stg_d;
    logic        cal_q, cal_d;
    logic [31:0] q_q, q_d;
    logic        valid_q, valid_d;

    logic        slip;
    logic        last_slot;
    logic [31:0] word_arrival;
    logic [31:0] word_out;

    assign slip      = CE & CALIB & ~cal_q;
    assign last_slot = (cnt_q == 5'd31);

    // Staging holds bits in arrival order; the final bit goes straight into the output word.
    assign word_arrival = {D, stg_q};

    generate
        for (genvar gi = 0; gi < 31; gi++) begin : g_stage
            assign stg_d[gi] = (CE && cnt_q == 5'(gi)) ? D : stg_q[gi];
        end
        for (genvar gi = 0; gi < 32; gi++) begin : g_order
            if (LSB_FIRST) begin : g_lsb
                assign word_out[gi] = word_arrival[gi];
            end else begin : g_msb
                assign word_out[gi] = word_arrival[31 - gi];
            end
        end
    endgenerate

    // A slip freezes the counter so the next accepted bit reuses the slot, and suppresses completion.
    always_comb begin
        cnt_d   = cnt_q;
        q_d     = q_q;
        valid_d = 1'b0;
        cal_d   = cal_q;
        if (CE) begin
            cal_d = CALIB;
            if (!slip) begin
                cnt_d = cnt_q + 5'd1;
                if (last_slot) begin
                    q_d     = word_out;
                    valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q   <= 5'd0;
            stg_q   <= 31'd0;
            cal_q   <= 1'b0;
            q_q     <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            stg_q   <= stg_d;
            cal_q   <= cal_d;
            q_q     <= q_d;
            valid_q <= valid_d;
        end
    end

    assign Q     = q_q;
    assign VALID = valid_q;
    assign S0    = cnt_q[0];
    assign S1    = cnt_q[1];
    assign S2    = cnt_q[2];
    assign S3    = cnt_q[3];
    assign S4    = cnt_q[4];

endmodule
